hdc_im_responder: RTL
=====================

Name: hdc_im_responder

Overview:
Serves item-memory (IM), negative-projection and positive-projection hypervectors for one modality to the spatial encoder. It answers the encoder's addr/spatial_valid requests with ready/valid-handshaked data. The top level instantiates three copies, one per modality, and their outputs drive sramN_ready/valid, IMOut_modX_D and projM_modX_neg/pos. A host-side load port fills the three internal memories before inference starts.

Parameters:
HV_DIMENSION, `HV_DIMENSION, hypervector width in bits
DEPTH, 256, entries per memory; legal range 1..256
ADDR_WIDTH, 8, request/load address width
READ_LATENCY, 2, cycles from request accept to data valid; must be >=1

Ports:
Clk_CI  in  1  clock
Reset_RI  in  1  asynchronous reset, active-high
ReqValid_SI  in  1  encoder request valid (spatial_valid_X)
DataReady_SI  in  1  encoder ready for data (spatial_ready_X)
ReqAddr_DI  in  ADDR_WIDTH  request address (addr_modX)
ReqReady_SO  out  3  per-memory request ready {IM,neg,pos} (sram ready)
DataValid_SO  out  3  per-memory data valid {IM,neg,pos} (sram valid)
IMOut_DO  out  HV_DIMENSION  IM vector
ProjNeg_DO  out  HV_DIMENSION  negative projection vector
ProjPos_DO  out  HV_DIMENSION  positive projection vector
Load_SI  in  1  load request
LoadSel_DI  in  2  0=IM, 1=neg, 2=pos, 3=discard
LoadAddr_DI  in  ADDR_WIDTH  load address
LoadData_DI  in  HV_DIMENSION  load data
LoadReady_SO  out  1  load accepted this cycle
AddrErr_SO  out  1  sticky out-of-range flag

Behaviour:
- Reset (asynchronous, Reset_RI=1): FSM=IDLE; all outputs 0, including data regs and AddrErr_SO; latency counter=0. Memory contents are not reset.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - ReqReady_SO=3'b111 iff !Load_SI, otherwise 0.
  - LoadReady_SO = Load_SI.
  - Load and request in the same cycle: the load wins and the request is not accepted (its ready is low).
  - A load writes the selected memory at the next edge. Sel=3 and addr>=DEPTH are dropped silently.
- Request accept = ReqValid_SI && ReqReady_SO[0]. On accept, latch the address, clear the counter and go to READ.
- READ:
  - ReqReady_SO=0, LoadReady_SO=0.
  - Count READ_LATENCY-1 further cycles.
  - On the final count, register all three vectors and go to RESP. DataValid_SO rises exactly READ_LATENCY cycles after the accept edge.
- RESP:
  - DataValid_SO=3'b111; data held stable.
  - When DataReady_SI=1, the handshake completes: DataValid_SO drops next cycle and FSM returns to IDLE.
  - ReqReady_SO stays 0 in RESP, so a back-to-back request is accepted at the earliest one cycle after the handshake.
- Latched address >= DEPTH: data = all zeros, AddrErr_SO set to 1 until reset. The handshake proceeds normally.
- Only one request is outstanding at a time. All three memories always answer together, so the three ready bits are identical and the three valid bits are identical.
- Reset mid-READ/RESP: the transaction is abandoned. No valid is produced after reset is released.
- ReqAddr_DI is sampled only at accept; later changes are ignored.

Decomposition:
- Shared const.vh: HV_DIMENSION, the LoadSel encodings (SEL_IM=0, SEL_NEG=1, SEL_POS=2), and the FSM state encodings.
- One sub-module, hdc_hv_mem: a single-port DEPTH x HV_DIMENSION memory with a registered read and a write enable.
  - Three instances.
  - The memory read counts as one cycle of READ_LATENCY.

Test Plan:
- Load IM[5]=0xA5.., neg[5]=0x0F.., pos[5]=0xF0..; request addr 5 with DataReady=1 -> DataValid=111 exactly 2 cycles after accept, vectors match, IDLE the cycle after.
- Request addr 7, hold DataReady=0 for 10 cycles -> valid stays 111, data stable, ReqReady=000 throughout; release -> one-cycle handshake.
- Load_SI=1 and ReqValid=1 in the same IDLE cycle -> LoadReady=1, ReqReady=000, write lands; request accepted the next cycle and returns the new value.
- DEPTH=200, request addr 250 -> zero vectors, AddrErr_SO=1 and stays 1 through later good requests until reset.
- Assert Reset_RI asynchronously mid-READ -> outputs 0 immediately, no valid after release, next request served normally.
- Back-to-back requests on addrs 0,1,2 with DataReady tied 1 -> accepts spaced READ_LATENCY+2 cycles apart, in-order correct data.

Source files
------------

// File: rtl/hdc_im_responder_pkg.sv
// Shared constants for the HDC item-memory responder: vector width, load
// selector encodings, FSM states and a range-check helper.
package hdc_im_responder_pkg;

  localparam int HV_DIMENSION = 64;

  localparam logic [1:0] SEL_IM  = 2'd0;
  localparam logic [1:0] SEL_NEG = 2'd1;
  localparam logic [1:0] SEL_POS = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/hdc_im_responder_if.sv
// Encoder request/response and host load signals of one modality responder.
interface hdc_im_responder_if
  import hdc_im_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int HV_DIM     = HV_DIMENSION
);
  logic                  ReqValid_SI;
  logic                  DataReady_SI;
  logic [ADDR_WIDTH-1:0] ReqAddr_DI;
  logic [2:0]            ReqReady_SO;
  logic [2:0]            DataValid_SO;
  logic [HV_DIM-1:0]     IMOut_DO;
  logic [HV_DIM-1:0]     ProjNeg_DO;
  logic [HV_DIM-1:0]     ProjPos_DO;
  logic                  Load_SI;
  logic [1:0]            LoadSel_DI;
  logic [ADDR_WIDTH-1:0] LoadAddr_DI;
  logic [HV_DIM-1:0]     LoadData_DI;
  logic                  LoadReady_SO;
  logic                  AddrErr_SO;

  modport slave (
    input  ReqValid_SI, DataReady_SI, ReqAddr_DI,
    input  Load_SI, LoadSel_DI, LoadAddr_DI, LoadData_DI,
    output ReqReady_SO, DataValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO,
    output LoadReady_SO, AddrErr_SO
  );

  modport master (
    output ReqValid_SI, DataReady_SI, ReqAddr_DI,
    output Load_SI, LoadSel_DI, LoadAddr_DI, LoadData_DI,
    input  ReqReady_SO, DataValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO,
    input  LoadReady_SO, AddrErr_SO
  );
endinterface

// File: rtl/hdc_im_responder_hv_mem.sv
// Single-port DEPTH x HV_DIM hypervector memory with write enable and a
// registered read; out-of-range accesses are ignored.
module hdc_hv_mem
  import hdc_im_responder_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int HV_DIM     = HV_DIMENSION
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [HV_DIM-1:0]     i_wdata,
  output logic [HV_DIM-1:0]     o_rdata
);

  logic [HV_DIM-1:0] r_mem [DEPTH];
  logic [HV_DIM-1:0] r_rdata;
  logic              w_ok;

  assign w_ok    = addr_in_range(32'(i_addr), DEPTH);
  assign o_rdata = r_rdata;

  // Storage array write and registered read port (contents intentionally unreset)
  always_ff @(posedge i_clk) begin
    if (i_we && w_ok) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re && w_ok) begin
      r_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/hdc_im_responder.sv
// Per-modality responder: serves IM / negative / positive projection vectors
// to the spatial encoder and accepts host loads while idle.
module hdc_im_responder
  import hdc_im_responder_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int HV_DIM       = HV_DIMENSION
) (
  input  logic                Clk_CI,
  input  logic                Reset_RI,
  hdc_im_responder_if.slave   bus
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e                r_state;
  state_e                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_valid;
  logic                  r_err;
  logic [HV_DIM-1:0]     r_im;
  logic [HV_DIM-1:0]     r_neg;
  logic [HV_DIM-1:0]     r_pos;

  logic                  w_req_ready;
  logic                  w_load_ready;
  logic                  w_accept;
  logic                  w_final;
  logic                  w_hs;
  logic                  w_ok;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [2:0]            w_we;
  logic [HV_DIM-1:0]     w_rd_im;
  logic [HV_DIM-1:0]     w_rd_neg;
  logic [HV_DIM-1:0]     w_rd_pos;

  // State register
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake decode; a load in IDLE blocks the request
  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_load_ready = 1'b0;
    w_accept     = 1'b0;
    w_final      = 1'b0;
    w_hs         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Reset_RI) begin
          w_next = ST_IDLE;
        end else begin
          w_load_ready = bus.Load_SI;
          w_req_ready  = !bus.Load_SI;
          w_accept     = bus.ReqValid_SI && !bus.Load_SI;
          w_next       = w_accept ? ST_READ : ST_IDLE;
        end
      end
      ST_READ: begin
        if (r_cnt == CNT_W'(READ_LATENCY - 1)) begin
          w_final = 1'b1;
          w_next  = ST_RESP;
        end else begin
          w_next = ST_READ;
        end
      end
      ST_RESP: begin
        w_hs   = bus.DataReady_SI;
        w_next = bus.DataReady_SI ? ST_IDLE : ST_RESP;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Memory read is launched at accept so it overlaps the first latency cycle
  assign w_mem_addr = w_load_ready ? bus.LoadAddr_DI : bus.ReqAddr_DI;
  assign w_we[0]    = w_load_ready && (bus.LoadSel_DI == SEL_IM);
  assign w_we[1]    = w_load_ready && (bus.LoadSel_DI == SEL_NEG);
  assign w_we[2]    = w_load_ready && (bus.LoadSel_DI == SEL_POS);
  assign w_ok       = addr_in_range(32'(r_addr), DEPTH);

  hdc_hv_mem #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .HV_DIM(HV_DIM)) u_mem_im (
    .i_clk(Clk_CI), .i_we(w_we[0]), .i_re(w_accept), .i_addr(w_mem_addr),
    .i_wdata(bus.LoadData_DI), .o_rdata(w_rd_im)
  );

  hdc_hv_mem #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .HV_DIM(HV_DIM)) u_mem_neg (
    .i_clk(Clk_CI), .i_we(w_we[1]), .i_re(w_accept), .i_addr(w_mem_addr),
    .i_wdata(bus.LoadData_DI), .o_rdata(w_rd_neg)
  );

  hdc_hv_mem #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .HV_DIM(HV_DIM)) u_mem_pos (
    .i_clk(Clk_CI), .i_we(w_we[2]), .i_re(w_accept), .i_addr(w_mem_addr),
    .i_wdata(bus.LoadData_DI), .o_rdata(w_rd_pos)
  );

  // Request address latch, latency counter, output vectors and flags
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_im    <= '0;
      r_neg   <= '0;
      r_pos   <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.ReqAddr_DI;
        r_cnt  <= '0;
      end else if (r_state == ST_READ) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_final) begin
        r_valid <= 1'b1;
        r_im    <= w_ok ? w_rd_im  : '0;
        r_neg   <= w_ok ? w_rd_neg : '0;
        r_pos   <= w_ok ? w_rd_pos : '0;
        r_err   <= r_err | !w_ok;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.ReqReady_SO  = {3{w_req_ready}};
  assign bus.LoadReady_SO = w_load_ready;
  assign bus.DataValid_SO = {3{r_valid}};
  assign bus.IMOut_DO     = r_im;
  assign bus.ProjNeg_DO   = r_neg;
  assign bus.ProjPos_DO   = r_pos;
  assign bus.AddrErr_SO   = r_err;

endmodule
